// File: rtl/plru_if.sv
// Request/response bus of the tree-PLRU engine: one request in, one response strobe out.
interface plru_if #(
  parameter int SET_BITS = 15,
  parameter int WAY_BITS = 3
);
  logic                req_valid;
  logic [1:0]          req_op;
  logic [SET_BITS-1:0] req_set;
  logic [WAY_BITS-1:0] req_way;
  logic                req_ready;
  logic                rsp_valid;
  logic [WAY_BITS-1:0] rsp_way;
  logic [SET_BITS-1:0] rsp_set;

  modport master (
    output req_valid, req_op, req_set, req_way,
    input  req_ready, rsp_valid, rsp_way, rsp_set
  );

  modport slave (
    input  req_valid, req_op, req_set, req_way,
    output req_ready, rsp_valid, rsp_way, rsp_set
  );
endinterface

// File: rtl/plru_engine.sv
// Tree pseudo-LRU replacement engine: per-set heap-ordered tree bits, one request per cycle,
// response one cycle after acceptance, and a bulk clear sweep that zeroes every set.
//
// state | meaning
// IDLE  | accepting requests
// CLEAR | writing zero tree bits to set r_cnt, one set per cycle
module plru_engine #(
  parameter int WAYS = 8,
  parameter int SETS = 32768
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_clear,
  output logic   o_busy,
  plru_if.slave  bus
);
  localparam int WAY_BITS  = $clog2(WAYS);
  localparam int SET_BITS  = $clog2(SETS);
  localparam int TREE_BITS = WAYS - 1;
  localparam logic [SET_BITS:0] CNT_LAST = (SET_BITS + 1)'(SETS - 1);

  localparam logic [1:0] OP_ACCESS = 2'd0;
  localparam logic [1:0] OP_VICTIM = 2'd1;
  localparam logic [1:0] OP_INV    = 2'd2;
  localparam logic [1:0] OP_RSVD   = 2'd3;

  if (WAYS < 2 || WAYS > 64 || (WAYS & (WAYS - 1)) != 0) begin : g_bad_ways
    $error("plru_engine: WAYS must be a power of two in 2..64");
  end
  if (SETS < 2 || (SETS & (SETS - 1)) != 0) begin : g_bad_sets
    $error("plru_engine: SETS must be a power of two >= 2");
  end

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t               r_state, w_state_nxt;
  logic [SET_BITS:0]    r_cnt, w_cnt_nxt;
  logic                 w_clr_we;
  logic                 w_accept;

  logic [TREE_BITS-1:0] r_mem [SETS];

  logic                 r_v;
  logic [1:0]           r_op;
  logic [SET_BITS-1:0]  r_set;
  logic [WAY_BITS-1:0]  r_way;

  logic                 r_rsp_valid;
  logic [WAY_BITS-1:0]  r_rsp_way;
  logic [SET_BITS-1:0]  r_rsp_set;

  logic [TREE_BITS-1:0] w_tree, w_tree_nxt;
  logic [WAY_BITS-1:0]  w_vway, w_way_sel;
  logic [WAY_BITS:0]    w_node;
  logic                 w_bit;
  logic                 w_we;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr_we    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_clear) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        w_clr_we = 1'b1;
        if (i_clear) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = CLEAR;
    endcase
  end

  assign o_busy        = (r_state == CLEAR);
  assign bus.req_ready = (r_state == IDLE) && !i_clear && !i_rst;
  assign w_accept      = bus.req_valid && bus.req_ready;

  // Walk the stored tree for the victim, then rewrite only the nodes on the chosen path.
  always_comb begin
    w_tree     = r_mem[r_set];
    w_vway     = '0;
    w_node     = '0;
    w_bit      = 1'b0;
    for (int l = 0; l < WAY_BITS; l++) begin
      w_bit = w_tree[w_node[WAY_BITS-1:0]];
      w_vway[WAY_BITS-1-l] = w_bit;
      w_node = (w_node << 1) + {{WAY_BITS{1'b0}}, 1'b1} + {{WAY_BITS{1'b0}}, w_bit};
    end
    w_way_sel  = (r_op == OP_VICTIM) ? w_vway : r_way;
    w_tree_nxt = w_tree;
    w_node     = '0;
    for (int l = 0; l < WAY_BITS; l++) begin
      w_bit = w_way_sel[WAY_BITS-1-l];
      w_tree_nxt[w_node[WAY_BITS-1:0]] = (r_op == OP_INV) ? w_bit : ~w_bit;
      w_node = (w_node << 1) + {{WAY_BITS{1'b0}}, 1'b1} + {{WAY_BITS{1'b0}}, w_bit};
    end
  end

  assign w_we = r_v && (r_op != OP_RSVD) && !i_rst;

  // In-flight writes and sweep writes never share an edge: nothing is accepted in CLEAR.
  always_ff @(posedge i_clk) begin
    if (w_clr_we && !i_rst) begin
      r_mem[r_cnt[SET_BITS-1:0]] <= '0;
    end else if (w_we) begin
      r_mem[r_set] <= w_tree_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v         <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_way   <= '0;
      r_rsp_set   <= '0;
    end else begin
      r_v         <= w_accept;
      r_rsp_valid <= r_v;
      if (w_accept) begin
        r_op  <= bus.req_op;
        r_set <= bus.req_set;
        r_way <= bus.req_way;
      end
      if (r_v) begin
        r_rsp_way <= w_way_sel;
        r_rsp_set <= r_set;
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_way   = r_rsp_way;
  assign bus.rsp_set   = r_rsp_set;
endmodule

// File: tb/tb_plru_engine.sv
// Directed bench for plru_engine: WAYS=8, 2 and 64 instances with 16 sets each,
// sharing clock, reset and clear.
module tb_plru_engine;
  localparam logic [1:0] OP_ACCESS = 2'd0;
  localparam logic [1:0] OP_VICTIM = 2'd1;
  localparam logic [1:0] OP_INV    = 2'd2;
  localparam logic [1:0] OP_RSVD   = 2'd3;

  logic clk;
  logic rst;
  logic clear;
  logic busy8, busy2, busy64;
  int   checks;
  int   errors;

  plru_if #(.SET_BITS(4), .WAY_BITS(3)) b8 ();
  plru_if #(.SET_BITS(4), .WAY_BITS(1)) b2 ();
  plru_if #(.SET_BITS(4), .WAY_BITS(6)) b64 ();

  plru_engine #(.WAYS(8), .SETS(16)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_clear(clear), .o_busy(busy8), .bus(b8));
  plru_engine #(.WAYS(2), .SETS(16)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_clear(clear), .o_busy(busy2), .bus(b2));
  plru_engine #(.WAYS(64), .SETS(16)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_clear(clear), .o_busy(busy64), .bus(b64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    b8.req_valid = 1'b0;  b8.req_op = 2'd0;  b8.req_set = '0;  b8.req_way = '0;
    b2.req_valid = 1'b0;  b2.req_op = 2'd0;  b2.req_set = '0;  b2.req_way = '0;
    b64.req_valid = 1'b0; b64.req_op = 2'd0; b64.req_set = '0; b64.req_way = '0;
  endtask

  task automatic req8(input logic [1:0] op, input logic [3:0] set, input logic [2:0] way);
    b8.req_valid = 1'b1;
    b8.req_op    = op;
    b8.req_set   = set;
    b8.req_way   = way;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy8 && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic do_clear();
    int n;
    clear = 1'b1;
    step();
    clear = 1'b0;
    wait_idle(n);
    checks++;
    if (busy8 !== 1'b0) begin
      errors++;
      $display("FAIL clear_done: busy=%b required 0 after %0d cycles", busy8, n);
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    clear = 1'b0;
    idle_bus();
    step();
    step();
    rst = 1'b0;
    checks++;
    if (busy8 !== 1'b1 || b8.req_ready !== 1'b0 || b8.rsp_valid !== 1'b0 ||
        b8.rsp_way !== 3'd0 || b8.rsp_set !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b ready=%b rsp_valid=%b way=%0d set=%0d required 1 0 0 0 0",
               busy8, b8.req_ready, b8.rsp_valid, b8.rsp_way, b8.rsp_set);
    end
    wait_idle(n);
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL reset_busy_len: busy cycles=%0d required 16", n);
    end
    checks++;
    if (b8.req_ready !== 1'b1 || busy2 !== 1'b0 || busy64 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: ready=%b busy2=%b busy64=%b required 1 0 0",
               b8.req_ready, busy2, busy64);
    end
  endtask

  task automatic test_zero_sets();
    for (int s = 0; s < 16; s++) begin
      req8(OP_VICTIM, 4'(s), 3'd0);
      step();
      idle_bus();
      step();
      checks++;
      if (b8.rsp_valid !== 1'b1 || b8.rsp_way !== 3'd0 || b8.rsp_set !== 4'(s)) begin
        errors++;
        $display("FAIL zero_set: set %0d valid=%b way=%0d rsp_set=%0d required 1 0 %0d",
                 s, b8.rsp_valid, b8.rsp_way, b8.rsp_set, s);
      end
    end
    step();
    checks++;
    if (b8.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rsp_pulse_width: rsp_valid=%b required 0", b8.rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    int exp_way [4] = '{0, 4, 2, 6};
    do_clear();
    req8(OP_VICTIM, 4'd5, 3'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) idle_bus();
      step();
      checks++;
      if (b8.rsp_valid !== 1'b1 || b8.rsp_way !== 3'(exp_way[i]) || b8.rsp_set !== 4'd5) begin
        errors++;
        $display("FAIL b2b_victim[%0d]: valid=%b way=%0d set=%0d required 1 %0d 5",
                 i, b8.rsp_valid, b8.rsp_way, b8.rsp_set, exp_way[i]);
      end
    end
  endtask

  task automatic test_access();
    do_clear();
    req8(OP_ACCESS, 4'd3, 3'd0); step();
    req8(OP_ACCESS, 4'd3, 3'd4); step();
    req8(OP_ACCESS, 4'd3, 3'd2); step();
    req8(OP_ACCESS, 4'd3, 3'd6); step();
    req8(OP_VICTIM, 4'd3, 3'd0); step();
    checks++;
    if (b8.rsp_valid !== 1'b1 || b8.rsp_way !== 3'd6) begin
      errors++;
      $display("FAIL access_echo: valid=%b way=%0d required 1 6", b8.rsp_valid, b8.rsp_way);
    end
    idle_bus();
    step();
    checks++;
    if (b8.rsp_valid !== 1'b1 || b8.rsp_way !== 3'd1) begin
      errors++;
      $display("FAIL access_victim: valid=%b way=%0d required 1 1", b8.rsp_valid, b8.rsp_way);
    end
  endtask

  task automatic test_inv_hint();
    do_clear();
    req8(OP_INV, 4'd9, 3'd5); step();
    req8(OP_VICTIM, 4'd9, 3'd0); step();
    checks++;
    if (b8.rsp_valid !== 1'b1 || b8.rsp_way !== 3'd5 || b8.rsp_set !== 4'd9) begin
      errors++;
      $display("FAIL inv_echo: valid=%b way=%0d set=%0d required 1 5 9",
               b8.rsp_valid, b8.rsp_way, b8.rsp_set);
    end
    req8(OP_VICTIM, 4'd10, 3'd0); step();
    checks++;
    if (b8.rsp_way !== 3'd5 || b8.rsp_set !== 4'd9) begin
      errors++;
      $display("FAIL inv_victim: way=%0d set=%0d required 5 9", b8.rsp_way, b8.rsp_set);
    end
    idle_bus();
    step();
    checks++;
    if (b8.rsp_valid !== 1'b1 || b8.rsp_way !== 3'd0 || b8.rsp_set !== 4'd10) begin
      errors++;
      $display("FAIL inv_isolation: valid=%b way=%0d set=%0d required 1 0 10",
               b8.rsp_valid, b8.rsp_way, b8.rsp_set);
    end
  endtask

  task automatic test_reserved();
    do_clear();
    req8(OP_RSVD, 4'd7, 3'd6); step();
    req8(OP_VICTIM, 4'd7, 3'd0); step();
    checks++;
    if (b8.rsp_valid !== 1'b1 || b8.rsp_way !== 3'd6) begin
      errors++;
      $display("FAIL rsvd_echo: valid=%b way=%0d required 1 6", b8.rsp_valid, b8.rsp_way);
    end
    idle_bus();
    step();
    checks++;
    if (b8.rsp_way !== 3'd0) begin
      errors++;
      $display("FAIL rsvd_no_update: way=%0d required 0", b8.rsp_way);
    end
  endtask

  task automatic test_clear_collision();
    int n;
    step();
    clear = 1'b1;
    req8(OP_VICTIM, 4'd1, 3'd0);
    #1;
    checks++;
    if (b8.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL collide_ready: ready=%b required 0", b8.req_ready);
    end
    step();
    clear = 1'b0;
    idle_bus();
    checks++;
    if (busy8 !== 1'b1 || b8.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL collide_busy: busy=%b rsp_valid=%b required 1 0", busy8, b8.rsp_valid);
    end
    step();
    checks++;
    if (b8.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL collide_no_rsp: rsp_valid=%b required 0", b8.rsp_valid);
    end
    wait_idle(n);
    checks++;
    if (n !== 15) begin
      errors++;
      $display("FAIL collide_sweep_len: remaining busy cycles=%0d required 15", n);
    end
  endtask

  task automatic test_inflight_clear();
    int n;
    req8(OP_ACCESS, 4'd2, 3'd3);
    step();
    idle_bus();
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (b8.rsp_valid !== 1'b1 || b8.rsp_way !== 3'd3 || busy8 !== 1'b1) begin
      errors++;
      $display("FAIL inflight_rsp: valid=%b way=%0d busy=%b required 1 3 1",
               b8.rsp_valid, b8.rsp_way, busy8);
    end
    wait_idle(n);
    req8(OP_VICTIM, 4'd2, 3'd0);
    step();
    idle_bus();
    step();
    checks++;
    if (b8.rsp_valid !== 1'b1 || b8.rsp_way !== 3'd0) begin
      errors++;
      $display("FAIL inflight_swept: valid=%b way=%0d required 1 0", b8.rsp_valid, b8.rsp_way);
    end
  endtask

  task automatic test_clear_restart();
    int n;
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 5; i++) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    wait_idle(n);
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL clear_restart_len: busy cycles after restart=%0d required 16", n);
    end
  endtask

  task automatic test_ways();
    int exp2 [4]  = '{0, 1, 0, 1};
    int exp64 [2] = '{0, 32};
    do_clear();
    b2.req_valid  = 1'b1; b2.req_op  = OP_VICTIM; b2.req_set  = 4'd4; b2.req_way  = '0;
    b64.req_valid = 1'b1; b64.req_op = OP_VICTIM; b64.req_set = 4'd4; b64.req_way = '0;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) idle_bus();
      step();
      checks++;
      if (b2.rsp_valid !== 1'b1 || b2.rsp_way !== 1'(exp2[i])) begin
        errors++;
        $display("FAIL ways2[%0d]: valid=%b way=%0d required 1 %0d",
                 i, b2.rsp_valid, b2.rsp_way, exp2[i]);
      end
      if (i < 2) begin
        checks++;
        if (b64.rsp_valid !== 1'b1 || b64.rsp_way !== 6'(exp64[i])) begin
          errors++;
          $display("FAIL ways64[%0d]: valid=%b way=%0d required 1 %0d",
                   i, b64.rsp_valid, b64.rsp_way, exp64[i]);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    clear  = 1'b0;
    idle_bus();
    test_reset();
    test_zero_sets();
    test_back_to_back();
    test_access();
    test_inv_hint();
    test_reserved();
    test_clear_collision();
    test_inflight_clear();
    test_clear_restart();
    test_ways();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/plru_engine.md
PLRU_ENGINE -- requirements
Module: plru_engine

Interface
REQ-001 Parameter WAYS, default 8, associativity; SHALL be a power of two in 2..64, else elaboration error.
REQ-002 Parameter SETS, default 32768, number of sets; SHALL be a power of two >= 2.
REQ-003 Derived WAY_BITS = clog2(WAYS), SET_BITS = clog2(SETS), TREE_BITS = WAYS-1 (7 at default); not overridable.
REQ-004 clk  in  1  sole clock, all state rising-edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 clear  in  1  request bulk reinitialisation of all sets.
REQ-007 req_valid  in  1  request present.
REQ-008 req_op  in  2  0=ACCESS (hit on req_way), 1=VICTIM (select LRU way, then mark it MRU), 2=INV_HINT (make req_way next victim), 3=reserved.
REQ-009 req_set  in  SET_BITS  target set index.
REQ-010 req_way  in  WAY_BITS  way for ACCESS/INV_HINT; ignored for VICTIM.
REQ-011 req_ready  out  1  request accepted this cycle when req_valid && req_ready.
REQ-012 rsp_valid  out  1  one-cycle response strobe.
REQ-013 rsp_way  out  WAY_BITS  victim way (VICTIM) or echoed req_way (ACCESS/INV_HINT).
REQ-014 rsp_set  out  SET_BITS  echoed set of the response.
REQ-015 busy  out  1  high while clearing.

Function
REQ-016 Per set SHALL store TREE_BITS tree bits, heap-indexed: node 0 root, children of n are 2n+1 (left) and 2n+2 (right); leaves left-to-right are ways 0..WAYS-1.
REQ-017 Bit value 0 SHALL mean LRU side is left, 1 means right.
REQ-018 VICTIM SHALL walk from root following bit values; reached leaf is rsp_way.
REQ-019 ACCESS and VICTIM SHALL update every node on the path to the chosen way so it points away from that way (set 1 if way is in left subtree, 0 if right); off-path bits unchanged.
REQ-020 INV_HINT SHALL update path nodes to point toward req_way; off-path bits unchanged.
REQ-021 Reserved op SHALL be accepted, produce rsp_valid with rsp_way=req_way, and leave state unchanged.
REQ-022 Latency: request accepted at edge N SHALL give rsp_valid=1 for exactly one cycle after edge N+1 with state written at edge N+1.
REQ-023 Throughput one request per cycle; back-to-back requests to the same set SHALL observe the previous request's update (forwarding), never stale state.
REQ-024 FSM states IDLE, CLEAR. IDLE->CLEAR on clear=1 or rst. CLEAR writes all-zero tree bits to set index cnt, cnt increments 0..SETS-1, CLEAR->IDLE after writing SETS-1.
REQ-025 req_ready SHALL be 1 only in IDLE with clear=0; busy SHALL be 1 exactly in CLEAR.
REQ-026 clear=1 and req_valid=1 same cycle: clear wins, request not accepted.
REQ-027 clear=1 while in CLEAR SHALL restart cnt at 0.
REQ-028 A response already in flight when clear arrives SHALL still complete its rsp_valid pulse; its write SHALL precede the clear sweep of that set.
REQ-029 cnt SHALL be SET_BITS+1 wide; no wrap past SETS-1.

Reset
REQ-030 rst SHALL force state CLEAR, cnt=0, rsp_valid=0, rsp_way=0, rsp_set=0, busy=1, req_ready=0, and cancel any in-flight response.
REQ-031 rst asserted mid-clear SHALL restart the sweep at set 0; busy deasserts SETS cycles after last rst-high edge.
REQ-032 Tree storage needs no reset of its own; post-reset clear sweep defines it.

Verification
REQ-033 rst 1 cycle, SETS=16 -> busy=1 for 16 cycles, req_ready=1 on cycle 17, all sets read zero.
REQ-034 WAYS=8, after clear, four VICTIM to set 5 back-to-back -> rsp_way 0,4,2,6 on consecutive cycles.
REQ-035 After clear, ACCESS way 0, way 4, way 2, way 6 on set 3, then VICTIM set 3 -> rsp_way 1.
REQ-036 After clear, INV_HINT way 5 set 9, then VICTIM set 9 -> rsp_way 5; set 10 VICTIM -> 0 (isolation).
REQ-037 clear and req_valid asserted same cycle -> req_ready=0, no rsp_valid for that request, busy=1 next cycle.
REQ-038 WAYS=2 and WAYS=64 builds: alternating VICTIM on one set -> WAYS=2 gives 0,1,0,1; WAYS=64 first two give 0,32.
